// File: rtl/seq_det_prog.sv
// seq_det_prog: programmable serial sequence detector.
//   Compares the most recent pat_len valid bits of the serial stream against a
//   loaded pattern. Overlapping or non-overlapping detection is selectable, and
//   a saturating counter tallies matches.
// Ports:
//   clk, reset_n             clock and asynchronous active-low reset
//   in, in_valid             serial bit and its qualifier
//   cfg_load                 one-cycle pulse that latches pat / pat_len / overlap_en
//   pat, pat_len, overlap_en pattern (pat[pat_len-1] arrives first), length, mode
//   cnt_clr                  synchronous clear of match_cnt
//   out                      Mealy match: combinational, high in the completing cycle
//   out_q                    out delayed by one cycle
//   match_cnt                saturating match count
//   cfg_err                  sticky flag, set when a cfg_load is rejected
module seq_det_prog #(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] PAT_RST = 8'b0000_1011,
  parameter int                 LEN_RST = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in,
  input  logic                         in_valid,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           pat,
  input  logic [$clog2(MAX_LEN+1)-1:0] pat_len,
  input  logic                         overlap_en,
  input  logic                         cnt_clr,
  output logic                         out,
  output logic                         out_q,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         cfg_err
);
  localparam int LW = $clog2(MAX_LEN+1);

  logic [MAX_LEN-1:0] pat_r;
  logic [LW-1:0]      len_r;
  logic               ovl_r;
  logic [MAX_LEN-2:0] hist;   // newest bit at [0]
  logic [LW-1:0]      since;  // valid bits eligible for a match, saturates at MAX_LEN

  logic [MAX_LEN-1:0] win, mask;
  logic               hit, since_ok, load_ok;

  // Candidate window: the stored history followed by the current bit.
  assign win = {hist, in};

  // Only the low len_r pattern bits take part in the compare.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
    assign mask[i] = (LW'(i) < len_r);
  end

  assign hit      = ((win ^ pat_r) & mask) == '0;
  // since >= len-1, written as since+1 >= len to avoid an underflow.
  assign since_ok = ({1'b0, since} + (LW+1)'(1)) >= {1'b0, len_r};
  assign load_ok  = cfg_load && (pat_len >= LW'(2)) && (pat_len <= LW'(MAX_LEN));

  // Any cfg_load cycle discards the serial bit, accepted or rejected; a rejected
  // load therefore leaves the detection progress exactly where it was.
  assign out = reset_n & in_valid & ~cfg_load & since_ok & hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_r <= PAT_RST;
      len_r <= LW'(LEN_RST);
      ovl_r <= 1'b0;
      hist  <= '0;
      since <= '0;
      cfg_err <= 1'b0;
    end else if (cfg_load) begin
      if (load_ok) begin
        pat_r <= pat;
        len_r <= pat_len;
        ovl_r <= overlap_en;
        hist  <= '0;
        since <= '0;
      end else begin
        cfg_err <= 1'b1;
      end
    end else if (in_valid) begin
      hist <= win[MAX_LEN-2:0];
      if (out && !ovl_r)
        since <= '0;  // consumed bits may not contribute to a later match
      else if (since != LW'(MAX_LEN))
        since <= since + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= 1'b0;
      match_cnt <= '0;
    end else begin
      out_q <= out;
      if (cnt_clr)
        match_cnt <= '0;  // clear has priority over a coincident match
      else if (out && !(&match_cnt))
        match_cnt <= match_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_seq_det_prog.sv
// Directed bench for seq_det_prog: a default instance plus a CNT_W=2 instance
// sharing the same stimulus, used for the counter saturation checks.
module tb_seq_det_prog;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       in, in_valid, cfg_load, overlap_en, cnt_clr;
  logic [7:0] pat;
  logic [3:0] pat_len;
  logic       out, out_q, cfg_err;
  logic [7:0] match_cnt;
  logic       out2, out_q2, cfg_err2;
  logic [1:0] cnt2;

  int ntests = 0;
  int nfail  = 0;
  logic last_out = 1'b0;

  always #5 clk = ~clk;

  seq_det_prog dut (
    .clk(clk), .reset_n(reset_n), .in(in), .in_valid(in_valid),
    .cfg_load(cfg_load), .pat(pat), .pat_len(pat_len), .overlap_en(overlap_en),
    .cnt_clr(cnt_clr), .out(out), .out_q(out_q), .match_cnt(match_cnt),
    .cfg_err(cfg_err));

  seq_det_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .in(in), .in_valid(in_valid),
    .cfg_load(cfg_load), .pat(pat), .pat_len(pat_len), .overlap_en(overlap_en),
    .cnt_clr(cnt_clr), .out(out2), .out_q(out_q2), .match_cnt(cnt2),
    .cfg_err(cfg_err2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One serial cycle: drive, check out and out_q mid-cycle, advance.
  task automatic step(input string tag, input logic b, input logic v,
                      input logic eo, input logic clr);
    in = b; in_valid = v; cnt_clr = clr;
    @(negedge clk);
    chk({tag, ".out"}, {31'b0, out}, {31'b0, eo});
    chk({tag, ".out_q"}, {31'b0, out_q}, {31'b0, last_out});
    last_out = eo;
    @(posedge clk); #1;
    in_valid = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic load(input string tag, input logic [7:0] p, input logic [3:0] l,
                      input logic ov, input logic vin);
    pat = p; pat_len = l; overlap_en = ov; cfg_load = 1'b1; in = 1'b1; in_valid = vin;
    @(negedge clk);
    chk({tag, ".out"}, {31'b0, out}, 32'd0);
    @(posedge clk); #1;
    cfg_load = 1'b0; in_valid = 1'b0;
    last_out = 1'b0;
  endtask

  task automatic run19(input string tag, input logic [1:19] e);
    logic [1:19] s;
    s = 19'b1011011101010110111;
    for (int i = 1; i <= 19; i++) step(tag, s[i], 1'b1, e[i], 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; in = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    pat = '0; pat_len = '0; overlap_en = 1'b0;
    #1;
    chk("rst.out_q", {31'b0, out_q}, 32'd0);
    chk("rst.cnt", {24'b0, match_cnt}, 32'd0);
    chk("rst.cfg_err", {31'b0, cfg_err}, 32'd0);
    chk("rst.out", {31'b0, out}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // Reset configuration (1011, non-overlap): matches at bits 4 and 15.
    run19("nov", 19'b0001000000000010000);
    chk("nov.cnt", {24'b0, match_cnt}, 32'd2);
    chk("nov.cnt2", {30'b0, cnt2}, 32'd2);
    step("clr", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr.cnt", {24'b0, match_cnt}, 32'd0);

    // Overlapping 1011; the valid bit presented during the load is discarded.
    load("ld_ov", 8'b0000_1011, 4'd4, 1'b1, 1'b1);
    run19("ov", 19'b0001001000000010010);
    chk("ov.cnt", {24'b0, match_cnt}, 32'd4);
    chk("ov.cnt2_sat", {30'b0, cnt2}, 32'd3);

    // Gaps: invalid 1s must neither shift nor match.
    load("ld_gap", 8'b0000_1011, 4'd4, 1'b1, 1'b0);
    step("gap", 1'b1, 1'b1, 1'b0, 1'b0);
    step("gap", 1'b0, 1'b1, 1'b0, 1'b0);
    step("gap", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("gap_idle", 1'b1, 1'b0, 1'b0, 1'b0);
    step("gap_last", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("gap.cnt", {24'b0, match_cnt}, 32'd5);

    // Rejected loads in mid-sequence keep config and progress.
    step("ill", 1'b1, 1'b1, 1'b0, 1'b0);
    step("ill", 1'b0, 1'b1, 1'b0, 1'b0);
    load("ld_len1", 8'hFF, 4'd1, 1'b0, 1'b0);
    chk("ill.cfg_err", {31'b0, cfg_err}, 32'd1);
    load("ld_len9", 8'hFF, 4'd9, 1'b0, 1'b0);
    step("ill", 1'b1, 1'b1, 1'b0, 1'b0);
    step("ill_hit", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("ill.cnt", {24'b0, match_cnt}, 32'd6);
    chk("ill.cfg_err_sticky", {31'b0, cfg_err}, 32'd1);

    // Full-length all-ones pattern, overlapping: nine 1s match on bits 8 and 9.
    load("ld_ff", 8'hFF, 4'd8, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) step("ff", 1'b1, 1'b1, i >= 8, 1'b0);
    chk("ff.cnt", {24'b0, match_cnt}, 32'd8);

    // pat_len=2 with upper pattern bits set (ignored): "11", non-overlap.
    load("ld_len2", 8'hF3, 4'd2, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) step("len2", 1'b1, 1'b1, (i % 2) == 0, 1'b0);
    chk("len2.cnt", {24'b0, match_cnt}, 32'd10);

    // 1011 x5 overlapping, then a clear coincident with a match.
    load("ld_rep", 8'b0000_1011, 4'd4, 1'b1, 1'b0);
    for (int r = 0; r < 5; r++) begin
      step("rep", 1'b1, 1'b1, 1'b0, 1'b0);
      step("rep", 1'b0, 1'b1, 1'b0, 1'b0);
      step("rep", 1'b1, 1'b1, 1'b0, 1'b0);
      step("rep", 1'b1, 1'b1, 1'b1, 1'b0);
    end
    chk("rep.cnt", {24'b0, match_cnt}, 32'd15);
    chk("rep.cnt2_sat", {30'b0, cnt2}, 32'd3);
    step("clrhit", 1'b1, 1'b1, 1'b0, 1'b0);
    step("clrhit", 1'b0, 1'b1, 1'b0, 1'b0);
    step("clrhit", 1'b1, 1'b1, 1'b0, 1'b0);
    step("clrhit", 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clrhit.cnt", {24'b0, match_cnt}, 32'd0);
    chk("clrhit.cnt2", {30'b0, cnt2}, 32'd0);

    // Mid-sequence reset discards progress and restores the reset config.
    step("mid", 1'b1, 1'b1, 1'b0, 1'b0);
    step("mid", 1'b0, 1'b1, 1'b0, 1'b0);
    step("mid", 1'b1, 1'b1, 1'b0, 1'b0);
    in = 1'b1; in_valid = 1'b1; reset_n = 1'b0;
    #2;
    chk("mid.rst_out", {31'b0, out}, 32'd0);
    chk("mid.rst_out_q", {31'b0, out_q}, 32'd0);
    chk("mid.rst_cfg_err", {31'b0, cfg_err}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; reset_n = 1'b1; last_out = 1'b0;
    step("post", 1'b1, 1'b1, 1'b0, 1'b0);
    step("post", 1'b0, 1'b1, 1'b0, 1'b0);
    step("post", 1'b1, 1'b1, 1'b0, 1'b0);
    step("post_hit", 1'b1, 1'b1, 1'b1, 1'b0);
    step("post_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post.cnt", {24'b0, match_cnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/seq_det_prog.md
SEQ_DET_PROG -- requirements
Module: seq_det_prog

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits (range 2..16).
REQ-002 Parameter CNT_W, default 8, width of the match counter.
REQ-003 Parameter PAT_RST, default 8'b0000_1011, pattern loaded at reset (MAX_LEN bits).
REQ-004 Parameter LEN_RST, default 4, pattern length loaded at reset.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 in  input  1  serial data bit.
REQ-008 in_valid  input  1  in is sampled only in cycles where in_valid=1.
REQ-009 cfg_load  input  1  one-cycle pulse; latches pat, pat_len, overlap_en.
REQ-010 pat  input  MAX_LEN  pattern; pat[pat_len-1] is the first bit received, pat[0] the last.
REQ-011 pat_len  input  $clog2(MAX_LEN+1)  pattern length.
REQ-012 overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-013 cnt_clr  input  1  synchronous clear of match_cnt.
REQ-014 out  output  1  Mealy match: combinational, high in the cycle whose valid bit completes a match.
REQ-015 out_q  output  1  Moore match: out registered, high exactly one cycle after out.
REQ-016 match_cnt  output  CNT_W  saturating count of matches.
REQ-017 cfg_err  output  1  sticky flag: a cfg_load with illegal pat_len was rejected.

Function
REQ-018 The block SHALL keep a history of the last MAX_LEN-1 valid bits and a run counter "since", counting valid bits since the last reset, config load or (non-overlap) match, saturating at MAX_LEN.
REQ-019 out SHALL be 1 iff in_valid=1, since >= len-1, and {last len-1 history bits, in} equals pat[len-1:0] under the active configuration.
REQ-020 Bits with in_valid=0 SHALL NOT shift history, change since, or assert out.
REQ-021 On a match with overlap_en=0, since SHALL become 0, so no bit of a matched sequence contributes to a later match.
REQ-022 On a match with overlap_en=1, since SHALL increment normally; matched bits remain eligible.
REQ-023 match_cnt SHALL increment by 1 on each cycle with out=1, saturating at 2^CNT_W-1.
REQ-024 cnt_clr SHALL zero match_cnt; if cnt_clr and out coincide, match_cnt SHALL become 0 (clear wins).
REQ-025 cfg_load with 2 <= pat_len <= MAX_LEN SHALL latch pat, pat_len, overlap_en, set since=0 and clear history; out SHALL be 0 in the load cycle and in_valid in that cycle is discarded.
REQ-026 cfg_load with illegal pat_len SHALL keep the previous configuration and progress unchanged and set cfg_err=1; cfg_err clears only on reset.
REQ-027 Pattern bits above pat_len-1 SHALL be ignored.
REQ-028 Inputs in, pat, pat_len, overlap_en are don't-care outside their sampling cycles.

Reset
REQ-029 reset_n=0 SHALL immediately force: history=0, since=0, out_q=0, match_cnt=0, cfg_err=0, configuration = PAT_RST/LEN_RST/overlap_en=0; out SHALL be 0 while reset_n=0.
REQ-030 Reset asserted mid-sequence SHALL discard all partial progress; detection restarts from the first valid bit after release.

Verification
REQ-031 Reset config, overlap_en=0, in_valid=1, stream 1,0,1,1,0,1,1,1,0,1,0,1,0,1,1,0,1,1,1 -> out high on bits 4 and 15 only; match_cnt=2; out_q high one cycle after each.
REQ-032 Same stream after cfg_load pat=1011, pat_len=4, overlap_en=1 -> out on bits 4, 7, 15, 18; match_cnt=4.
REQ-033 Stream 1,0,1 with in_valid dropped for 3 cycles before final 1 -> single match on the final valid 1; no out during gaps.
REQ-034 cfg_load pat_len=1 (then pat_len=MAX_LEN+1) -> cfg_err=1, config unchanged, 1011 still detected; cfg_load pat=8'b11111111, pat_len=8, overlap on, nine 1s -> matches on bits 8 and 9.
REQ-035 CNT_W=2, overlap on, stream of 1011 repeated 5 times -> match_cnt saturates at 3; cnt_clr coincident with a match -> match_cnt=0.
REQ-036 Reset asserted after bits 1,0,1 then released, then 1,0,1,1 -> no out on the first post-reset 1; single match on post-reset bit 4.
